// File: rtl/tile_pkg.sv
// Shared types and helpers for the piano-tiles row judge and its controller.
package tile_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    localparam int LANE_EMPTY = 0;

    // One-hot in key_n bit order: lane 1 maps to bit n-1 (MSB), lane n to bit 0.
    // Codes outside 1..n give all zeros.
    function automatic logic [31:0] lane_onehot(input logic [31:0] lane, input int n);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && lane == 32'(n - i)) res[i] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer plus falling-edge detector for active-low keys.
// press_o pulses for one cycle per key press; flops reset to "released".
module key_edge_sync #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] key_n_i,
    output logic [W-1:0] press_o
);

    logic [W-1:0] sync1_q, sync2_q, prev_q, press_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            press_q <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            press_q <= prev_q & ~sync2_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/tile_judge.sv
// Bottom-row hit judge: evaluates key presses against the target lane on a
// go/done handshake and keeps saturating score and streak counters.
module tile_judge
    import tile_pkg::*;
#(
    parameter int  N_LANES  = 4,
    parameter int  WINDOW   = 1024,
    parameter int  SCORE_W  = 16,
    parameter int  STREAK_W = 8,
    localparam int LANE_W   = $clog2(N_LANES + 1)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                go,
    input  logic [LANE_W-1:0]   lane,
    input  logic [N_LANES-1:0]  key_n,
    input  logic                clear_score,
    output logic                done,
    output logic                correct,
    output logic                incorrect,
    output logic                miss,
    output logic [SCORE_W-1:0]  score,
    output logic [STREAK_W-1:0] streak
);

    localparam int TIMER_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [N_LANES-1:0] press;

    key_edge_sync #(.W(N_LANES)) u_keys (
        .clock   (clock),
        .resetn  (resetn),
        .key_n_i (key_n),
        .press_o (press)
    );

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                done_q, done_d;
    logic                correct_q, correct_d;
    logic                incorrect_q, incorrect_d;
    logic                miss_q, miss_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [31:0]         target;
    logic                lane_bad;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        timer_d     = timer_q;
        done_d      = done_q;
        correct_d   = correct_q;
        incorrect_d = incorrect_q;
        miss_d      = miss_q;
        score_d     = score_q;
        streak_d    = streak_q;
        target      = lane_onehot(32'(lane_q), N_LANES);
        lane_bad    = (lane == LANE_W'(LANE_EMPTY)) || (32'(lane) > 32'(N_LANES));

        case (state_q)
            IDLE: begin
                done_d      = 1'b0;
                correct_d   = 1'b0;
                incorrect_d = 1'b0;
                miss_d      = 1'b0;
                if (go) begin
                    lane_d = lane;
                    if (lane_bad) begin
                        // Empty row: complete the handshake with no verdict.
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        timer_d = TIMER_W'(WINDOW - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!go) begin
                    state_d = IDLE;
                end else if (|press) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                    if (32'(press) == target) begin
                        correct_d = 1'b1;
                        if (score_q != '1)  score_d  = score_q + SCORE_W'(1);
                        if (streak_q != '1) streak_d = streak_q + STREAK_W'(1);
                    end else begin
                        incorrect_d = 1'b1;
                        streak_d    = '0;
                    end
                end else if (timer_q == '0) begin
                    miss_d   = 1'b1;
                    done_d   = 1'b1;
                    streak_d = '0;
                    state_d  = DONE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            DONE: begin
                if (!go) begin
                    done_d      = 1'b0;
                    correct_d   = 1'b0;
                    incorrect_d = 1'b0;
                    miss_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_score) begin
            score_d  = '0;
            streak_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            correct_q   <= 1'b0;
            incorrect_q <= 1'b0;
            miss_q      <= 1'b0;
            score_q     <= '0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            timer_q     <= timer_d;
            done_q      <= done_d;
            correct_q   <= correct_d;
            incorrect_q <= incorrect_d;
            miss_q      <= miss_d;
            score_q     <= score_d;
            streak_q    <= streak_d;
        end
    end

    assign done      = done_q;
    assign correct   = correct_q;
    assign incorrect = incorrect_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign streak    = streak_q;

endmodule
